// File: rtl/fir_pipe_ctrl.sv
// Sequencer for the pipelined FIR datapath: coefficient load, datapath clear,
// then clock-enable gating of the delay line with output valid and backpressure.
module fir_pipe_ctrl #(
  parameter  int unsigned TAPS     = 8,
  parameter  int unsigned PIPE_LAT = 4,
  parameter  int unsigned COEF_W   = 16,
  localparam int unsigned AW       = $clog2(TAPS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              coef_load,
  input  logic              coef_vld,
  input  logic [COEF_W-1:0] coef_in,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              pipe_en,
  output logic              pipe_clr,
  output logic              coef_we,
  output logic [AW-1:0]     coef_addr,
  output logic [COEF_W-1:0] coef_wdata,
  output logic              busy
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_LOAD  = 2'd1;
  localparam logic [1:0] S_CLEAR = 2'd2;
  localparam logic [1:0] S_RUN   = 2'd3;

  // fill_cnt saturates at PIPE_LAT, so it needs room for that value itself
  localparam int unsigned FW        = $clog2(PIPE_LAT + 1);
  localparam logic [FW-1:0] FILL_MAX  = FW'(PIPE_LAT);
  localparam logic [FW-1:0] FILL_THR  = FW'(PIPE_LAT - 1);
  localparam logic [AW-1:0] LAST_ADDR = AW'(TAPS - 1);

  logic [1:0]    state_q, state_d;
  logic [AW-1:0] load_cnt_q, load_cnt_d;
  logic [FW-1:0] fill_q, fill_d;
  logic          out_valid_q, out_valid_d;
  logic          run_rdy;
  logic          accept;

  // State and counter registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      load_cnt_q  <= '0;
      fill_q      <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      load_cnt_q  <= load_cnt_d;
      fill_q      <= fill_d;
      out_valid_q <= out_valid_d;
    end
  end

  // Next-state, counter update and strobe decode
  always_comb begin
    state_d     = state_q;
    load_cnt_d  = load_cnt_q;
    fill_d      = fill_q;
    out_valid_d = out_valid_q;
    run_rdy     = 1'b0;
    accept      = 1'b0;
    pipe_clr    = 1'b0;
    coef_we     = 1'b0;
    coef_addr   = '0;
    coef_wdata  = '0;

    case (state_q)
      S_IDLE: begin
        if (coef_load) begin
          state_d     = S_LOAD;
          fill_d      = '0;
          out_valid_d = 1'b0;
        end
      end

      S_LOAD: begin
        coef_we    = coef_vld;
        coef_addr  = load_cnt_q;
        coef_wdata = coef_in;
        if (coef_vld) begin
          if (load_cnt_q == LAST_ADDR) begin
            load_cnt_d = '0;
            state_d    = S_CLEAR;
          end else begin
            load_cnt_d = load_cnt_q + AW'(1);
          end
        end
      end

      S_CLEAR: begin
        pipe_clr    = 1'b1;
        fill_d      = '0;
        out_valid_d = 1'b0;
        state_d     = S_RUN;
      end

      S_RUN: begin
        // A reload request blocks acceptance in the same cycle
        run_rdy = ~coef_load & (~out_valid_q | out_ready);
        accept  = in_valid & run_rdy;
        if (coef_load) begin
          state_d     = S_LOAD;
          fill_d      = '0;
          out_valid_d = 1'b0;
        end else if (accept) begin
          out_valid_d = (fill_q >= FILL_THR);
          fill_d      = (fill_q >= FILL_MAX) ? FILL_MAX : fill_q + FW'(1);
        end else if (out_valid_q & out_ready) begin
          out_valid_d = 1'b0;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign in_ready  = run_rdy;
  assign pipe_en   = accept;
  assign out_valid = out_valid_q;
  assign busy      = (state_q != S_RUN);

endmodule
